pcm_dc_block: RTL and testbench

- First-order IIR DC-blocking high-pass filter.
- Sits directly downstream of the CIC3 PDM decimator. Consumes its 16-bit PCM strobe stream and removes DC offset and very-low-frequency drift.
- Delivers filtered samples through a 2-entry valid/ready output FIFO to the serializer/host interface.
- Transfer function: y[n] = x[n] - x[n-1] + (1 - 2^-SHIFT)*y[n-1], computed sequentially by a small FSM.

---
 rtl/pcm_dc_block_if.sv | 32 +++
 rtl/pcm_dc_block.sv | 229 ++++++++++++++++++++++
 tb/tb_pcm_dc_block.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcm_dc_block_if.sv
// pcm_dc_block_if
// Groups the PCM sample stream that feeds the DC blocker with the
// valid/ready stream it delivers.
//   in_valid / in_data   : one-cycle strobe and signed 16-bit sample from the decimator
//   out_valid / out_data : FIFO head valid and signed 16-bit filtered sample
//   out_ready            : consumer accepts the head when out_valid && out_ready
// Modports:
//   master : the environment side (decimator plus downstream consumer)
//   slave  : the pcm_dc_block side
interface pcm_dc_block_if;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/pcm_dc_block.sv
// pcm_dc_block
// First-order IIR DC-blocking high-pass filter placed after the CIC3 PDM
// decimator:  y[n] = x[n] - x[n-1] + (1 - 2^-SHIFT) * y[n-1].
// Each accepted sample walks IDLE -> DIFF -> UPDATE -> SAT (one cycle each),
// and the result is pushed into a 2-entry valid/ready output FIFO.
// Optional feature: define PCM_DCB_GAIN_EN to add a 3-bit 'gain' input that
// left-shifts the result (also in bypass) before the final 16-bit saturation.
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   pcm (slave)   : in_valid/in_data input strobe, out_valid/out_data/out_ready output FIFO head
//   bypass        : 1 = output the raw input sample; filter state still updates
//   gain          : (PCM_DCB_GAIN_EN only) output left shift, 0..7
//   overrun       : sticky, a sample or a result was dropped
//   overrun_clr   : clears overrun; a simultaneous new drop wins
//   busy          : FSM is not in IDLE
module pcm_dc_block #(
  parameter int SHIFT = 10,
  parameter int ACC_W = 19 + SHIFT
) (
  input  logic          clk,
  input  logic          rst,
  pcm_dc_block_if.slave pcm,
  input  logic          bypass,
`ifdef PCM_DCB_GAIN_EN
  input  logic [2:0]    gain,
`endif
  output logic          overrun,
  input  logic          overrun_clr,
  output logic          busy
);

  // Wide enough for the integer part of the accumulator shifted left by up to 7.
  localparam int R_W = ACC_W + 8;

  localparam logic signed [ACC_W:0]  ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]  ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [R_W-1:0]  OUT_MAX = R_W'(32767);
  localparam logic signed [R_W-1:0]  OUT_MIN = R_W'(-32768);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIFF,
    S_UPDATE,
    S_SAT
  } state_t;

  state_t                  state_q, state_d;
  logic signed [15:0]      x_q, x_d;
  logic signed [15:0]      x_prev_q, x_prev_d;
  logic signed [16:0]      diff_q, diff_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    primed_q, primed_d;
  logic signed [15:0]      head_q, head_d;
  logic signed [15:0]      tail_q, tail_d;
  logic [1:0]              count_q, count_d;
  logic                    overrun_q, overrun_d;

  logic [2:0]              gain_val;
  logic signed [ACC_W:0]   acc_ext;
  logic signed [ACC_W:0]   diff_scaled;
  logic signed [ACC_W:0]   acc_next;
  logic signed [ACC_W-1:0] acc_sat;
  logic signed [ACC_W-1:0] acc_int;
  logic signed [R_W-1:0]   r_base;
  logic signed [R_W-1:0]   r_gain;
  logic signed [15:0]      r_sat;
  logic                    push;
  logic                    pop;
  logic                    drop_busy;
  logic                    drop_full;

`ifdef PCM_DCB_GAIN_EN
  assign gain_val = gain;
`else
  assign gain_val = 3'd0;
`endif

  // Accumulator update one bit wider than the state so the leak and the new
  // difference can be summed without wrapping, then clamped back.
  always_comb begin
    acc_ext     = {acc_q[ACC_W-1], acc_q};
    diff_scaled = (ACC_W+1)'(diff_q) <<< SHIFT;
    acc_next    = acc_ext - (acc_ext >>> SHIFT) + diff_scaled;
    if (acc_next > ACC_MAX) begin
      acc_sat = ACC_MAX[ACC_W-1:0];
    end else if (acc_next < ACC_MIN) begin
      acc_sat = ACC_MIN[ACC_W-1:0];
    end else begin
      acc_sat = acc_next[ACC_W-1:0];
    end
  end

  // Output sample: integer part of the accumulator (or the raw input in
  // bypass), gain applied before the 16-bit clamp so the clamp sees it all.
  always_comb begin
    acc_int = acc_q >>> SHIFT;
    if (bypass) begin
      r_base = R_W'(x_q);
    end else begin
      r_base = R_W'(acc_int);
    end
    r_gain = r_base <<< gain_val;
    if (r_gain > OUT_MAX) begin
      r_sat = 16'sh7FFF;
    end else if (r_gain < OUT_MIN) begin
      r_sat = 16'sh8000;
    end else begin
      r_sat = r_gain[15:0];
    end
  end

  // Sequencer. The first difference after reset is forced to zero so the
  // filter does not see a step from the implicit x_prev = 0.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    x_prev_d = x_prev_q;
    diff_d   = diff_q;
    acc_d    = acc_q;
    primed_d = primed_q;
    unique case (state_q)
      S_IDLE: begin
        if (pcm.in_valid) begin
          x_d     = pcm.in_data;
          state_d = S_DIFF;
        end
      end
      S_DIFF: begin
        if (primed_q) begin
          diff_d = 17'(x_q) - 17'(x_prev_q);
        end else begin
          diff_d = 17'sd0;
        end
        x_prev_d = x_q;
        primed_d = 1'b1;
        state_d  = S_UPDATE;
      end
      S_UPDATE: begin
        acc_d   = acc_sat;
        state_d = S_SAT;
      end
      S_SAT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Two-entry FIFO with a registered head. A push into a full FIFO only
  // succeeds when the head leaves in the same cycle.
  always_comb begin
    push      = (state_q == S_SAT);
    pop       = (count_q != 2'd0) && pcm.out_ready;
    drop_busy = pcm.in_valid && (state_q != S_IDLE);
    drop_full = 1'b0;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (pop) begin
      if (count_q == 2'd2) begin
        head_d = tail_q;
        if (push) begin
          tail_d = r_sat;
        end else begin
          count_d = 2'd1;
        end
      end else begin
        if (push) begin
          head_d = r_sat;
        end else begin
          head_d  = 16'sd0;
          count_d = 2'd0;
        end
      end
    end else if (push) begin
      if (count_q == 2'd0) begin
        head_d  = r_sat;
        count_d = 2'd1;
      end else if (count_q == 2'd1) begin
        tail_d  = r_sat;
        count_d = 2'd2;
      end else begin
        drop_full = 1'b1;
      end
    end

    if (drop_busy || drop_full) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      x_prev_q  <= '0;
      diff_q    <= '0;
      acc_q     <= '0;
      primed_q  <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      x_prev_q  <= x_prev_d;
      diff_q    <= diff_d;
      acc_q     <= acc_d;
      primed_q  <= primed_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign pcm.out_valid = (count_q != 2'd0);
  assign pcm.out_data  = head_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_pcm_dc_block.sv
// tb_pcm_dc_block
// Self-checking bench for pcm_dc_block. A transaction-level model (filter
// arithmetic on longints, expected FIFO as a queue, 3-edge processing
// latency) is compared against the DUT outputs on every falling edge;
// directed scenarios add hand-computed literal expectations.
`timescale 1ns/1ps
module tb_pcm_dc_block;
  localparam int SHIFT = 10;
  localparam int ACC_W = 19 + SHIFT;

  logic clk;
  logic rst;
  logic bypass;
  logic overrun;
  logic overrun_clr;
  logic busy;
`ifdef PCM_DCB_GAIN_EN
  logic [2:0] gain;
`endif

  pcm_dc_block_if pcm();

  pcm_dc_block #(.SHIFT(SHIFT), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .pcm         (pcm),
    .bypass      (bypass),
`ifdef PCM_DCB_GAIN_EN
    .gain        (gain),
`endif
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .busy        (busy)
  );

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  // Model state
  int     m_fifo[$];
  int     m_pend = 0;
  int     m_x = 0;
  bit     m_overrun = 0;
  bit     m_primed = 0;
  int     m_xprev = 0;
  longint m_acc = 0;

  // Every sample popped by the consumer, in order
  int got[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int model_gain();
`ifdef PCM_DCB_GAIN_EN
    return int'(gain);
`else
    return 0;
`endif
  endfunction

  // One sample through the ideal filter: y = x - x_prev + (1 - 2^-SHIFT) y_prev,
  // with y held as a fixed-point number scaled by 2^SHIFT.
  function automatic int model_step(input int x, input bit byp);
    longint d;
    longint r;
    longint acc_lim;
    acc_lim = longint'(1) << (ACC_W - 1);
    d = m_primed ? longint'(x - m_xprev) : 0;
    m_primed = 1;
    m_xprev = x;
    m_acc = m_acc - (m_acc >>> SHIFT) + d * (longint'(1) << SHIFT);
    if (m_acc > acc_lim - 1) m_acc = acc_lim - 1;
    if (m_acc < -acc_lim) m_acc = -acc_lim;
    r = byp ? longint'(x) : (m_acc >>> SHIFT);
    r = r * (longint'(1) << model_gain());
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  // Model advance at each rising edge: a sample accepted at edge N produces
  // its result at edge N+3; the block ignores strobes until then.
  always @(posedge clk) begin
    bit pop;
    bit push;
    bit drop_busy;
    bit drop_full;
    int r;
    if (rst) begin
      m_fifo.delete();
      m_pend = 0;
      m_overrun = 0;
      m_primed = 0;
      m_xprev = 0;
      m_acc = 0;
    end else begin
      pop = (m_fifo.size() != 0) && pcm.out_ready;
      push = (m_pend == 1);
      drop_busy = pcm.in_valid && (m_pend != 0);
      drop_full = 0;
      r = 0;
      if (push) r = model_step(m_x, bypass);
      if (pop) void'(m_fifo.pop_front());
      if (push) begin
        if (m_fifo.size() < 2) m_fifo.push_back(r);
        else drop_full = 1;
      end
      if (m_pend != 0) begin
        m_pend = m_pend - 1;
      end else if (pcm.in_valid) begin
        m_x = int'(pcm.in_data);
        m_pend = 3;
      end
      if (drop_busy || drop_full) m_overrun = 1;
      else if (overrun_clr) m_overrun = 0;
    end
  end

  // Record what the consumer takes (pre-edge values at the handshake edge).
  always @(posedge clk) begin
    if (!rst && pcm.out_valid && pcm.out_ready) got.push_back(int'(pcm.out_data));
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("out_valid", longint'(pcm.out_valid), longint'(m_fifo.size() != 0));
      checkOutput("out_data", longint'(pcm.out_data), (m_fifo.size() != 0) ? longint'(m_fifo[0]) : 0);
      checkOutput("overrun", longint'(overrun), longint'(m_overrun));
      checkOutput("busy", longint'(busy), longint'(m_pend != 0));
    end
  end

  // One-cycle strobe, then idle so consecutive strobes are 'gap' edges apart.
  task automatic applyStimulus(input int x, input int gap);
    @(negedge clk);
    pcm.in_valid = 1'b1;
    pcm.in_data  = 16'(x);
    @(negedge clk);
    pcm.in_valid = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst            = 1'b1;
    pcm.in_valid   = 1'b0;
    pcm.in_data    = '0;
    pcm.out_ready  = 1'b1;
    bypass         = 1'b0;
    overrun_clr    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    got.delete();
  endtask

  task automatic wait_results(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (got.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("result count", longint'(got.size()), longint'(n));
  endtask

  initial begin
    int bad;
    rst           = 1'b1;
    pcm.in_valid  = 1'b0;
    pcm.in_data   = '0;
    pcm.out_ready = 1'b1;
    bypass        = 1'b0;
    overrun_clr   = 1'b0;
`ifdef PCM_DCB_GAIN_EN
    gain          = 3'd0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checking = 1;

    // Reset state
    checkOutput("reset out_valid", longint'(pcm.out_valid), 0);
    checkOutput("reset out_data", longint'(pcm.out_data), 0);
    checkOutput("reset overrun", longint'(overrun), 0);
    checkOutput("reset busy", longint'(busy), 0);

    // Constant input: pure DC never reaches the output
    reset_dut();
    for (int i = 0; i < 20; i++) applyStimulus(1000, 64);
    wait_results(20, 50);
    bad = 0;
    foreach (got[i]) if (got[i] != 0) bad++;
    checkOutput("constant nonzero outputs", longint'(bad), 0);
    checkOutput("constant overrun", longint'(overrun), 0);

    // Step response: 0,0,0,0,0 then 1000, 999, 998 and a slow decay
    reset_dut();
    for (int i = 0; i < 5; i++) applyStimulus(0, 5);
    for (int i = 0; i < 1000; i++) applyStimulus(1000, 5);
    wait_results(1005, 50);
    if (got.size() >= 1005) begin
      bad = 0;
      for (int i = 0; i < 5; i++) if (got[i] != 0) bad++;
      checkOutput("step leading zeros", longint'(bad), 0);
      checkOutput("step y0", longint'(got[5]), 1000);
      checkOutput("step y1", longint'(got[6]), 999);
      checkOutput("step y2", longint'(got[7]), 998);
      bad = 0;
      for (int i = 6; i < 1005; i++) if (got[i] > got[i-1] || got[i] < 0) bad++;
      checkOutput("step monotonic decay", longint'(bad), 0);
      checkOutput("step 1000th below 400", longint'(got[1004] < 400), 1);
    end

    // Saturation, positive: -32768 then 32767 gives a +65535 step -> clamps to 32767.
    // The following -32768 gives y = -65535 + 65535 - floor(65535*1024/1024)/1024... = -64
    // in accumulator terms: 67107840 - 65535 - 67107840 = -65535, >>>10 = -64.
    reset_dut();
    applyStimulus(-32768, 8);
    applyStimulus(32767, 8);
    applyStimulus(-32768, 8);
    wait_results(3, 20);
    if (got.size() >= 3) begin
      checkOutput("sat positive clamp", longint'(got[1]), 32767);
      checkOutput("sat after clamp", longint'(got[2]), -64);
    end

    // Saturation, negative: a -65535 step clamps to -32768
    reset_dut();
    applyStimulus(32767, 8);
    applyStimulus(-32768, 8);
    wait_results(2, 20);
    if (got.size() >= 2) checkOutput("sat negative clamp", longint'(got[1]), -32768);

    // Backpressure: prime with 100, then 300/600/900 with the consumer stalled.
    // Results 200 and 499 fill the FIFO; 799 is dropped.
    reset_dut();
    applyStimulus(100, 8);
    wait_results(1, 20);
    got.delete();
    @(negedge clk);
    pcm.out_ready = 1'b0;
    applyStimulus(300, 8);
    applyStimulus(600, 8);
    checkOutput("bp valid after 2", longint'(pcm.out_valid), 1);
    checkOutput("bp overrun after 2", longint'(overrun), 0);
    applyStimulus(900, 8);
    checkOutput("bp overrun after 3", longint'(overrun), 1);
    checkOutput("bp head", longint'(pcm.out_data), 200);
    pcm.out_ready = 1'b1;
    wait_results(2, 20);
    if (got.size() >= 2) begin
      checkOutput("bp pop first", longint'(got[0]), 200);
      checkOutput("bp pop second", longint'(got[1]), 499);
    end
    repeat (4) @(negedge clk);
    checkOutput("bp drained", longint'(got.size()), 2);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    checkOutput("bp overrun cleared", longint'(overrun), 0);

    // Busy drop and latency: strobes on two consecutive edges N, N+1
    reset_dut();
    @(negedge clk);
    pcm.in_valid = 1'b1;
    pcm.in_data  = 16'sd10;
    @(negedge clk);
    pcm.in_data  = 16'sd20;
    @(negedge clk);
    pcm.in_valid = 1'b0;
    checkOutput("drop overrun", longint'(overrun), 1);
    checkOutput("lat N+1 out_valid", longint'(pcm.out_valid), 0);
    @(negedge clk);
    checkOutput("lat N+2 out_valid", longint'(pcm.out_valid), 0);
    @(negedge clk);
    checkOutput("lat N+3 out_valid", longint'(pcm.out_valid), 1);
    repeat (10) @(negedge clk);
    checkOutput("drop single result", longint'(got.size()), 1);

    // Bypass passes the raw sample
    reset_dut();
    bypass = 1'b1;
    applyStimulus(-1234, 8);
    wait_results(1, 20);
    if (got.size() >= 1) checkOutput("bypass value", longint'(got[0]), -1234);
    bypass = 1'b0;

    // Reset while the sample is in UPDATE: nothing comes out
    reset_dut();
    @(negedge clk);
    pcm.in_valid = 1'b1;
    pcm.in_data  = 16'sd5000;
    @(negedge clk);
    pcm.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre-reset busy", longint'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort out_valid", longint'(pcm.out_valid), 0);
    checkOutput("abort busy", longint'(busy), 0);
    repeat (8) @(negedge clk);
    checkOutput("abort no output", longint'(got.size()), 0);

    repeat (4) @(negedge clk);
    checking = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
